rec_playback_ctrl: RTL and testbench

- Record/playback engine directly downstream of the UI control block.
- Consumes DO_RECORD / DO_PLAYBACK / DO_CLEAR and returns REC_TIME / REC_END_TIME for the UI progress bar.
- Moves codec samples to and from external sample memory through a req/ack handshake, paced by the codec sample strobe.

---
 rtl/rec_playback_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rec_playback_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_playback_ctrl.sv
// Record/playback engine: moves codec samples to/from external sample memory over a req/ack
// handshake. Define PLAYBACK_LOOP_EN to make playback wrap to the start of the recording.
//
// state      | meaning
// IDLE       | waiting for a command; REC_TIME holds its last value
// REC_WAIT   | recording, waiting for the next sample strobe
// REC_WR     | sample write outstanding
// REC_FULL   | memory full, waiting for DO_RECORD to drop
// PLAY_WAIT  | playing, waiting for the next sample strobe
// PLAY_RD    | sample read outstanding
// PLAY_END   | end of recording reached, emitting silence
// CLR_WR     | zeroing the stored recording, one write per ack
// CLR_DONE   | clear finished, waiting for DO_CLEAR to drop
module rec_playback_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 25,
  parameter int MAX_SAMPLES = 1048576
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DO_RECORD,
  input  logic              DO_PLAYBACK,
  input  logic              DO_CLEAR,
  input  logic              SAMPLE_TICK,
  input  logic [DATA_W-1:0] ADC_DATA,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic [ADDR_W-1:0] REC_TIME,
  output logic [ADDR_W-1:0] REC_END_TIME,
  output logic [DATA_W-1:0] PLAY_DATA,
  output logic              PLAY_VALID,
  output logic              BUSY,
  output logic              OVERRUN
);

  typedef enum logic [3:0] {
    S_IDLE, S_REC_WAIT, S_REC_WR, S_REC_FULL,
    S_PLAY_WAIT, S_PLAY_RD, S_PLAY_END, S_CLR_WR, S_CLR_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_SAMPLES);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rec_time, rec_end, mem_addr;
  logic [ADDR_W-1:0] time_inc, addr_inc;
  logic [DATA_W-1:0] wdata, play_data;
  logic              play_valid, overrun;

  assign time_inc = rec_time + ADDR_W'(1);
  assign addr_inc = mem_addr + ADDR_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (DO_CLEAR)         state_nxt = (rec_end == '0) ? S_CLR_DONE : S_CLR_WR;
        else if (DO_RECORD)   state_nxt = S_REC_WAIT;
        else if (DO_PLAYBACK) state_nxt = S_PLAY_WAIT;
      end
      S_REC_WAIT: begin
        if (!DO_RECORD)       state_nxt = S_IDLE;
        else if (SAMPLE_TICK) state_nxt = S_REC_WR;
      end
      S_REC_WR: begin
        if (MEM_ACK) begin
          if (!DO_RECORD)               state_nxt = S_IDLE;
          else if (time_inc == MAX_CNT) state_nxt = S_REC_FULL;
          else                          state_nxt = S_REC_WAIT;
        end
      end
      S_REC_FULL: if (!DO_RECORD) state_nxt = S_IDLE;
      S_PLAY_WAIT: begin
        if (!DO_PLAYBACK)                        state_nxt = S_IDLE;
        else if (SAMPLE_TICK && rec_end != '0)   state_nxt = S_PLAY_RD;
      end
      S_PLAY_RD: begin
        if (MEM_ACK) begin
          if (!DO_PLAYBACK) state_nxt = S_IDLE;
`ifdef PLAYBACK_LOOP_EN
          else              state_nxt = S_PLAY_WAIT;
`else
          else if (time_inc == rec_end) state_nxt = S_PLAY_END;
          else                          state_nxt = S_PLAY_WAIT;
`endif
        end
      end
      S_PLAY_END: if (!DO_PLAYBACK) state_nxt = S_IDLE;
      S_CLR_WR:   if (MEM_ACK && addr_inc == rec_end) state_nxt = S_CLR_DONE;
      S_CLR_DONE: if (!DO_CLEAR) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    MEM_REQ = 1'b0;
    MEM_WE  = 1'b0;
    BUSY    = (state != S_IDLE);
    case (state)
      S_REC_WR:  begin MEM_REQ = 1'b1; MEM_WE = 1'b1; end
      S_CLR_WR:  begin MEM_REQ = 1'b1; MEM_WE = 1'b1; end
      S_PLAY_RD: MEM_REQ = 1'b1;
      default: ;
    endcase
  end

  // Address and write data only change on the edge that raises a request or on its ack,
  // so they are stable for the whole time MEM_REQ is high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rec_time   <= '0;
      rec_end    <= '0;
      mem_addr   <= '0;
      wdata      <= '0;
      play_data  <= '0;
      play_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      play_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (DO_CLEAR) begin
            mem_addr <= '0;
            wdata    <= '0;
            if (rec_end == '0) rec_time <= '0;
          end else if (DO_RECORD) begin
            rec_time <= '0;
            rec_end  <= '0;
            overrun  <= 1'b0;
          end else if (DO_PLAYBACK) begin
            rec_time <= '0;
            overrun  <= 1'b0;
          end
        end
        S_REC_WAIT: begin
          if (DO_RECORD && SAMPLE_TICK) begin
            mem_addr <= rec_time;
            wdata    <= ADC_DATA;
          end
        end
        S_REC_WR: begin
          if (SAMPLE_TICK) overrun <= 1'b1;
          if (MEM_ACK) begin
            rec_time <= time_inc;
            rec_end  <= time_inc;
          end
        end
        S_PLAY_WAIT: begin
          if (DO_PLAYBACK && SAMPLE_TICK) begin
            if (rec_end == '0) begin
              play_data  <= '0;
              play_valid <= 1'b1;
            end else begin
              mem_addr <= rec_time;
            end
          end
        end
        S_PLAY_RD: begin
          if (SAMPLE_TICK) overrun <= 1'b1;
          if (MEM_ACK) begin
            play_data  <= MEM_RDATA;
            play_valid <= 1'b1;
`ifdef PLAYBACK_LOOP_EN
            rec_time   <= (time_inc == rec_end) ? '0 : time_inc;
`else
            rec_time   <= time_inc;
`endif
          end
        end
        S_PLAY_END: begin
          if (DO_PLAYBACK && SAMPLE_TICK) begin
            play_data  <= '0;
            play_valid <= 1'b1;
          end
        end
        S_CLR_WR: begin
          if (MEM_ACK) begin
            if (addr_inc == rec_end) begin
              rec_time <= '0;
              rec_end  <= '0;
            end else begin
              mem_addr <= addr_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign MEM_ADDR     = mem_addr;
  assign MEM_WDATA    = wdata;
  assign REC_TIME     = rec_time;
  assign REC_END_TIME = rec_end;
  assign PLAY_DATA    = play_data;
  assign PLAY_VALID   = play_valid;
  assign OVERRUN      = overrun;

endmodule

// File: tb/tb_rec_playback_ctrl.sv
// Bench for rec_playback_ctrl: random sample data and ack latency, checked against a
// sample-level model of memory contents and recording length.
module tb_rec_playback_ctrl;

  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        reset, do_record, do_playback, do_clear, sample_tick;
  logic [15:0] adc_data, mem_wdata, mem_rdata, play_data;
  logic        mem_req, mem_we, mem_ack, play_valid, busy, overrun;
  logic [24:0] mem_addr, rec_time, rec_end_time;

  rec_playback_ctrl #(.DATA_W(16), .ADDR_W(25), .MAX_SAMPLES(MAXS)) dut (
    .CLK(clk), .RESET(reset), .DO_RECORD(do_record), .DO_PLAYBACK(do_playback),
    .DO_CLEAR(do_clear), .SAMPLE_TICK(sample_tick), .ADC_DATA(adc_data),
    .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .REC_TIME(rec_time),
    .REC_END_TIME(rec_end_time), .PLAY_DATA(play_data), .PLAY_VALID(play_valid),
    .BUSY(busy), .OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // model of what the stored recording should be
  int m_end = 0;
  int exp_mem [0:15];

  // memory responder state
  logic [15:0] mem_model [0:15];
  bit          ack_hold  = 1'b0;
  bit          stray_ack = 1'b0;
  int          cnt = 0, lat = 2;
  logic [24:0] cap_addr;
  logic        cap_we;
  logic [15:0] cap_wd;
  int          wr_addr_q [$];
  int          wr_data_q [$];
  int          vd_q [$];
  int          vt_q [$];

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        stray_ack = 1'b0;
      end else if (mem_req) begin
        cnt++;
        if (cnt == 1) begin
          cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
        end else begin
          check("mem_stable", 32'(mem_addr != cap_addr || mem_we != cap_we ||
                (mem_we && mem_wdata != cap_wd)), 32'd0);
        end
        if (!ack_hold && cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr[3:0]] = mem_wdata;
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(int'(mem_wdata));
          end else begin
            mem_rdata = mem_model[mem_addr[3:0]];
          end
          cnt = 0;
          lat = $urandom_range(1, 3);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (play_valid) begin
        vd_q.push_back(int'(play_data));
        vt_q.push_back(int'(rec_time));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_tick(input logic [15:0] d);
    @(negedge clk);
    sample_tick = 1'b1;
    adc_data    = d;
    @(negedge clk);
    sample_tick = 1'b0;
    adc_data    = 16'($urandom);
  endtask

  task automatic record(input int n, input bit early_release);
    int m, d;
    int dq [$];
    do_record = 1'b1;
    repeat (2) @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete();
    for (int i = 0; i < n; i++) begin
      d = $urandom_range(0, 65535);
      dq.push_back(d);
      do_tick(16'(d));
      if (i >= MAXS) begin
        check("full_noreq", 32'(mem_req), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
      end
      if (!(early_release && i == n - 1)) repeat (8) @(negedge clk);
    end
    do_record = 1'b0;
    repeat (10) @(negedge clk);
    m = (n < MAXS) ? n : MAXS;
    check("rec_nwr", 32'(wr_addr_q.size()), 32'(m));
    for (int i = 0; i < m && i < wr_addr_q.size(); i++) begin
      check("rec_addr", 32'(wr_addr_q[i]), 32'(i));
      check("rec_data", 32'(wr_data_q[i]), 32'(dq[i]));
    end
    for (int i = 0; i < m; i++) exp_mem[i] = dq[i];
    m_end = m;
    check("rec_end", 32'(rec_end_time), 32'(m));
    check("rec_time", 32'(rec_time), 32'(m));
    check("rec_idle", 32'(busy), 32'd0);
  endtask

  task automatic playback(input int k);
    int e_d, e_t, fin;
    do_playback = 1'b1;
    repeat (2) @(negedge clk);
    vd_q.delete(); vt_q.delete();
    for (int i = 0; i < k; i++) begin
      do_tick(16'($urandom));
      repeat (8) @(negedge clk);
    end
    do_playback = 1'b0;
    repeat (4) @(negedge clk);
    check("play_cnt", 32'(vd_q.size()), 32'(k));
    for (int j = 0; j < k && j < vd_q.size(); j++) begin
      if (m_end == 0) begin
        e_d = 0; e_t = 0;
      end else begin
`ifdef PLAYBACK_LOOP_EN
        e_d = exp_mem[j % m_end];
        e_t = ((j % m_end) + 1) % m_end;
`else
        e_d = (j < m_end) ? exp_mem[j] : 0;
        e_t = (j < m_end) ? j + 1 : m_end;
`endif
      end
      check("play_data", 32'(vd_q[j]), 32'(e_d));
      check("play_time", 32'(vt_q[j]), 32'(e_t));
    end
`ifdef PLAYBACK_LOOP_EN
    fin = (m_end == 0) ? 0 : k % m_end;
`else
    fin = (k < m_end) ? k : m_end;
`endif
    check("play_hold", 32'(rec_time), 32'(fin));
    check("play_idle", 32'(busy), 32'd0);
  endtask

  task automatic clear_mem(input bit with_rec);
    int old;
    old = m_end;
    wr_addr_q.delete(); wr_data_q.delete();
    do_clear  = 1'b1;
    do_record = with_rec;
    repeat (60) @(negedge clk);
    check("clr_nwr", 32'(wr_addr_q.size()), 32'(old));
    for (int i = 0; i < old && i < wr_addr_q.size(); i++) begin
      check("clr_addr", 32'(wr_addr_q[i]), 32'(i));
      check("clr_data", 32'(wr_data_q[i]), 32'd0);
    end
    check("clr_end", 32'(rec_end_time), 32'd0);
    check("clr_time", 32'(rec_time), 32'd0);
    check("clr_held", 32'(busy), 32'd1);
    do_tick(16'hBEEF);
    repeat (6) @(negedge clk);
    check("clr_noretrig", 32'(wr_addr_q.size()), 32'(old));
    for (int i = 0; i < old; i++) exp_mem[i] = 0;
    m_end = 0;
    do_clear = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_release", 32'(busy), 32'(with_rec));
    do_record = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, d3;
    reset = 1'b1; do_record = 1'b0; do_playback = 1'b0; do_clear = 1'b0;
    sample_tick = 1'b0; adc_data = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_time", 32'(rec_time), 32'd0);
    check("rst_end", 32'(rec_end_time), 32'd0);
    check("rst_pdata", 32'(play_data), 32'd0);
    check("rst_pvalid", 32'(play_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;

    record(5, 1'b0);
    playback(7);
    for (int r = 0; r < 3; r++) begin
      record($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      playback($urandom_range(1, 9));
    end

    record(MAXS + 2, 1'b0);
    playback(MAXS + 1);

    record(3, 1'b1);
    clear_mem(1'b1);
    playback(2);
    clear_mem(1'b0);

    // ack withheld across two sample periods
    do_record = 1'b1;
    repeat (2) @(negedge clk);
    wr_addr_q.delete(); wr_data_q.delete();
    ack_hold = 1'b1;
    d0 = $urandom_range(0, 65535);
    do_tick(16'(d0));
    repeat (8) @(negedge clk);
    do_tick(16'($urandom));
    repeat (8) @(negedge clk);
    do_tick(16'($urandom));
    repeat (2) @(negedge clk);
    ack_hold = 1'b0;
    repeat (6) @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) check("ovr_data0", 32'(wr_data_q[0]), 32'(d0));
    check("ovr_time", 32'(rec_time), 32'd1);
    d3 = $urandom_range(0, 65535);
    do_tick(16'(d3));
    repeat (8) @(negedge clk);
    check("ovr_nwr2", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() > 1) begin
      check("ovr_addr1", 32'(wr_addr_q[1]), 32'd1);
      check("ovr_data1", 32'(wr_data_q[1]), 32'(d3));
    end
    do_record = 1'b0;
    repeat (3) @(negedge clk);
    check("ovr_sticky", 32'(overrun), 32'd1);
    do_record = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_restart_end", 32'(rec_end_time), 32'd0);
    do_record = 1'b0;
    repeat (2) @(negedge clk);
    m_end = 0;

    // reset while a write is outstanding
    do_record = 1'b1;
    repeat (2) @(negedge clk);
    do_tick(16'($urandom));
    repeat (8) @(negedge clk);
    ack_hold = 1'b1;
    do_tick(16'($urandom));
    repeat (2) @(negedge clk);
    check("mid_req", 32'(mem_req), 32'd1);
    check("mid_time", 32'(rec_time), 32'd1);
    reset = 1'b1; do_record = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_time", 32'(rec_time), 32'd0);
    check("mid_rst_end", 32'(rec_end_time), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    ack_hold = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete();
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("late_ack_busy", 32'(busy), 32'd0);
    check("late_ack_time", 32'(rec_time), 32'd0);
    check("late_ack_end", 32'(rec_end_time), 32'd0);
    check("late_ack_nwr", 32'(wr_addr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
